// File: rtl/fetch_ctrl.sv
// fetch_ctrl: in-order instruction fetch controller.
// Two-deep buffer/in-flight budget, PC tags, redirect squash.
module fetch_ctrl #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EXEC,
  input  logic [31:0] P_PC,
  input  logic        P_VALID,
  output logic        STALL,
  output logic        FLUSH,
  output logic [31:0] NEW_PC,
  input  logic        JMP_DO,
  input  logic [31:0] JMP_PC,
  input  logic        TRAP_DO,
  input  logic [31:0] TRAP_PC,
  output logic        INST_RDEN,
  output logic [31:0] INST_RDADDR,
  input  logic        INST_RDVALID,
  input  logic [31:0] INST_RDDATA,
  output logic        F_VALID,
  output logic [31:0] F_PC,
  output logic [31:0] F_INST,
  input  logic        D_READY
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    REDIR
  } state_t;

  localparam logic [2:0] BUDGET = 3'(FIFO_DEPTH);

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  out_q;
  logic [1:0]  disc_q;
  logic [1:0]  cnt_q;
  logic [31:0] tag_q [2];
  logic        tag_wr;
  logic        tag_rd;
  logic [31:0] buf_pc [2];
  logic [31:0] buf_inst [2];
  logic        buf_wr;
  logic        buf_rd;

  logic        redirect;
  logic        issue;
  logic        rsp_drop;
  logic        rsp_live;
  logic        rsp_take;
  logic        pop;
  logic [2:0]  occ;

  assign redirect = JMP_DO | TRAP_DO;
  assign occ = {1'b0, out_q} + {1'b0, disc_q}
             + {1'b0, cnt_q};
  assign issue = (state_q == FETCH) & P_VALID
               & ~redirect & (occ < BUDGET);

  // Stale reads are always the oldest ones, so any
  // response while disc is nonzero belongs to them.
  assign rsp_drop = INST_RDVALID & (disc_q != 2'd0);
  assign rsp_live = INST_RDVALID & (disc_q == 2'd0)
                  & (out_q != 2'd0);
  assign rsp_take = rsp_live & ~redirect;
  assign pop      = F_VALID & D_READY;

  assign INST_RDEN   = issue;
  assign INST_RDADDR = P_PC;
  assign STALL       = ~issue;
  assign FLUSH       = redirect;
  assign NEW_PC      = TRAP_DO ? TRAP_PC : JMP_PC;
  assign F_VALID     = (cnt_q != 2'd0) & ~redirect;
  assign F_PC        = buf_pc[buf_rd];
  assign F_INST      = buf_inst[buf_rd];

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a redirect wins from any state.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = REDIR;
    end else begin
      unique case (state_q)
        IDLE:    if (EXEC) state_d = FETCH;
        FETCH:   if (!EXEC) state_d = IDLE;
        REDIR:   state_d = EXEC ? FETCH : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Budget counters and queue pointers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q  <= 2'd0;
      disc_q <= 2'd0;
      cnt_q  <= 2'd0;
      tag_wr <= 1'b0;
      tag_rd <= 1'b0;
      buf_wr <= 1'b0;
      buf_rd <= 1'b0;
    end else if (redirect) begin
      disc_q <= disc_q + out_q
              - {1'b0, rsp_drop | rsp_live};
      out_q  <= 2'd0;
      cnt_q  <= 2'd0;
      tag_wr <= 1'b0;
      tag_rd <= 1'b0;
      buf_wr <= 1'b0;
      buf_rd <= 1'b0;
    end else begin
      out_q  <= out_q + {1'b0, issue}
              - {1'b0, rsp_live};
      disc_q <= disc_q - {1'b0, rsp_drop};
      cnt_q  <= cnt_q + {1'b0, rsp_take}
              - {1'b0, pop};
      if (issue)    tag_wr <= ~tag_wr;
      if (rsp_take) tag_rd <= ~tag_rd;
      if (rsp_take) buf_wr <= ~buf_wr;
      if (pop)      buf_rd <= ~buf_rd;
    end
  end

  // Tag and buffer storage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        tag_q[i]    <= 32'd0;
        buf_pc[i]   <= 32'd0;
        buf_inst[i] <= 32'd0;
      end
    end else begin
      if (issue) tag_q[tag_wr] <= P_PC;
      if (rsp_take) begin
        buf_pc[buf_wr]   <= tag_q[tag_rd];
        buf_inst[buf_wr] <= INST_RDDATA;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: fetch_ctrl bench with a queue-based
// reference model, a redirect table and random traffic.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EXEC;
  logic [31:0] P_PC;
  logic        P_VALID;
  logic        STALL;
  logic        FLUSH;
  logic [31:0] NEW_PC;
  logic        JMP_DO;
  logic [31:0] JMP_PC;
  logic        TRAP_DO;
  logic [31:0] TRAP_PC;
  logic        INST_RDEN;
  logic [31:0] INST_RDADDR;
  logic        INST_RDVALID;
  logic [31:0] INST_RDDATA;
  logic        F_VALID;
  logic [31:0] F_PC;
  logic [31:0] F_INST;
  logic        D_READY;

  fetch_ctrl #(.FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .EXEC(EXEC),
    .P_PC(P_PC), .P_VALID(P_VALID),
    .STALL(STALL), .FLUSH(FLUSH), .NEW_PC(NEW_PC),
    .JMP_DO(JMP_DO), .JMP_PC(JMP_PC),
    .TRAP_DO(TRAP_DO), .TRAP_PC(TRAP_PC),
    .INST_RDEN(INST_RDEN), .INST_RDADDR(INST_RDADDR),
    .INST_RDVALID(INST_RDVALID),
    .INST_RDDATA(INST_RDDATA),
    .F_VALID(F_VALID), .F_PC(F_PC), .F_INST(F_INST),
    .D_READY(D_READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } rd_t;

  typedef struct {
    bit          jmp;
    bit          trap;
    logic [31:0] jpc;
    logic [31:0] tpc;
    bit          exp_flush;
    logic [31:0] exp_newpc;
  } vec_t;

  rd_t         mem[$];
  logic [31:0] bufq[$];
  logic [31:0] got[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          quiet = 0;
  bit          fetch_now = 0;
  logic [31:0] pc = 32'd0;

  bit          k_rst, k_exec, k_pvalid, k_dready;
  bit          k_jmp, k_trap, spur_en, redir_on_rsp;
  bit          hit_rsp_redir;
  logic [31:0] k_jpc, k_tpc;
  int          lat_lo, lat_hi;

  logic        obs_fvalid, obs_stall, obs_rden, obs_flush;
  logic [31:0] obs_newpc;

  function automatic logic [31:0] memdata(
    input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check against model, advance model.
  task automatic step();
    bit          rsp, spur, redir, exp_issue, exp_fv;
    bit          fj;
    logic [31:0] npc;
    rd_t         e;
    #1;
    RST     = k_rst;
    EXEC    = k_exec;
    P_VALID = k_pvalid;
    P_PC    = pc;
    D_READY = k_dready;
    rsp  = !k_rst && quiet == 0 && mem.size() > 0
        && mem[0].due <= cyc;
    spur = !k_rst && quiet == 0 && mem.size() == 0
        && spur_en && ($urandom_range(7) == 0);
    INST_RDVALID = rsp | spur;
    INST_RDDATA  = rsp ? memdata(mem[0].addr) : $urandom;
    fj = 0;
    if (redir_on_rsp && rsp && !k_rst) begin
      fj = 1;
      redir_on_rsp = 0;
      hit_rsp_redir = 1;
    end
    JMP_DO  = k_jmp | fj;
    JMP_PC  = k_jpc;
    TRAP_DO = k_trap;
    TRAP_PC = k_tpc;
    redir = JMP_DO | TRAP_DO;
    npc = TRAP_DO ? TRAP_PC : JMP_PC;
    #1;
    obs_fvalid = F_VALID;
    obs_stall  = STALL;
    obs_rden   = INST_RDEN;
    obs_flush  = FLUSH;
    obs_newpc  = NEW_PC;
    if (k_rst) begin
      mem.delete();
      bufq.delete();
      fetch_now = 0;
      quiet = 4;
    end else begin
      exp_issue = fetch_now && P_VALID && !redir
               && (mem.size() + bufq.size() < 2);
      exp_fv = !redir && bufq.size() > 0;
      chk("rden", INST_RDEN, exp_issue);
      chk("stall", STALL, !exp_issue);
      if (exp_issue) chk("rdaddr", INST_RDADDR, pc);
      chk("flush", FLUSH, redir);
      if (redir) chk("new_pc", NEW_PC, npc);
      chk("f_valid", F_VALID, exp_fv);
      if (exp_fv) begin
        chk("f_pc", F_PC, bufq[0]);
        chk("f_inst", F_INST, memdata(bufq[0]));
      end
      if (exp_fv && D_READY) begin
        got.push_back(F_PC);
        void'(bufq.pop_front());
      end
      if (rsp) begin
        e = mem.pop_front();
        if (!e.stale && !redir) bufq.push_back(e.addr);
      end
      if (redir) begin
        bufq.delete();
        foreach (mem[i]) mem[i].stale = 1;
      end
      if (exp_issue) begin
        e.addr  = pc;
        e.due   = cyc + $urandom_range(lat_hi, lat_lo);
        e.stale = 0;
        mem.push_back(e);
      end
      if (redir) pc = npc;
      else if (exp_issue) pc = pc + 32'd4;
      fetch_now = EXEC && !redir;
      if (quiet > 0) quiet--;
    end
    cyc++;
    @(posedge CLK);
  endtask

  vec_t vt[6];
  logic [31:0] exp0;
  int          n;

  initial begin
    vt[0] = '{0, 0, 32'h0000_1234, 32'h0000_5678,
              0, 32'h0000_1234};
    vt[1] = '{1, 0, 32'h2000_0100, 32'h0000_5678,
              1, 32'h2000_0100};
    vt[2] = '{0, 1, 32'h0000_1234, 32'h2000_0040,
              1, 32'h2000_0040};
    vt[3] = '{1, 1, 32'h2000_0100, 32'h2000_0040,
              1, 32'h2000_0040};
    vt[4] = '{1, 0, 32'hFFFF_FFFC, 32'h1111_1110,
              1, 32'hFFFF_FFFC};
    vt[5] = '{0, 1, 32'hDEAD_BEEC, 32'h0000_0000,
              1, 32'h0000_0000};

    k_rst = 1; k_exec = 0; k_pvalid = 0; k_dready = 0;
    k_jmp = 0; k_trap = 0; k_jpc = 0; k_tpc = 0;
    spur_en = 0; redir_on_rsp = 0; hit_rsp_redir = 0;
    lat_lo = 1; lat_hi = 1;
    repeat (2) step();
    k_rst = 0;
    #1;
    chk("rst_f_valid", F_VALID, 0);
    chk("rst_rden", INST_RDEN, 0);
    chk("rst_flush", FLUSH, 0);
    chk("rst_new_pc", NEW_PC, 0);
    chk("rst_f_pc", F_PC, 0);
    chk("rst_f_inst", F_INST, 0);
    repeat (3) step();

    // Redirect priority table, idle core.
    for (int i = 0; i < 6; i++) begin
      k_jmp = vt[i].jmp;
      k_trap = vt[i].trap;
      k_jpc = vt[i].jpc;
      k_tpc = vt[i].tpc;
      step();
      chk("tbl_flush", obs_flush, vt[i].exp_flush);
      chk("tbl_new_pc", obs_newpc, vt[i].exp_newpc);
      chk("tbl_f_valid", obs_fvalid, 0);
    end
    k_jmp = 0; k_trap = 0; k_jpc = 0; k_tpc = 0;
    repeat (2) step();

    // Streaming with 1-cycle memory.
    pc = 32'h2000_0000;
    got.delete();
    k_exec = 1; k_pvalid = 1; k_dready = 1;
    repeat (20) step();
    for (int i = 0; i < 5; i++)
      chk("stream_seq",
          i < got.size() ? got[i] : 32'hFFFF_FFFF,
          32'h2000_0000 + 32'(4 * i));

    // Decode backpressure, then resume.
    k_dready = 0;
    repeat (5) step();
    chk("bp_f_valid", obs_fvalid, 1);
    chk("bp_stall", obs_stall, 1);
    chk("bp_rden", obs_rden, 0);
    exp0 = bufq.size() > 0 ? bufq[0] : pc;
    got.delete();
    k_dready = 1;
    repeat (15) step();
    for (int i = 0; i < 6; i++)
      chk("resume_seq",
          i < got.size() ? got[i] : 32'hFFFF_FFFF,
          exp0 + 32'(4 * i));

    // Jump with two reads outstanding.
    lat_lo = 4; lat_hi = 4;
    n = 0;
    while (mem.size() != 2 && n < 20) begin
      step();
      n++;
    end
    chk("two_outstanding", mem.size(), 2);
    k_jmp = 1; k_jpc = 32'h2000_0100;
    step();
    k_jmp = 0;
    chk("jmp_flush", obs_flush, 1);
    chk("jmp_new_pc", obs_newpc, 32'h2000_0100);
    got.delete();
    step();
    chk("jmp_flush_pulse", obs_flush, 0);
    repeat (20) step();
    chk("jmp_first",
        got.size() > 0 ? got[0] : 32'hFFFF_FFFF,
        32'h2000_0100);

    // Redirect coinciding with a response.
    lat_lo = 1; lat_hi = 1;
    k_jpc = 32'h2000_0200;
    redir_on_rsp = 1;
    hit_rsp_redir = 0;
    n = 0;
    while (!hit_rsp_redir && n < 20) begin
      step();
      n++;
    end
    chk("rsp_redir_seen", hit_rsp_redir, 1);
    redir_on_rsp = 0;
    got.delete();
    repeat (15) step();
    chk("rsp_redir_first",
        got.size() > 0 ? got[0] : 32'hFFFF_FFFF,
        32'h2000_0200);

    // Reset with a full buffer.
    k_dready = 0;
    repeat (6) step();
    chk("full_f_valid", obs_fvalid, 1);
    k_rst = 1;
    step();
    k_rst = 0;
    #1;
    chk("mid_rst_f_valid", F_VALID, 0);
    chk("mid_rst_rden", INST_RDEN, 0);
    k_dready = 1;
    repeat (10) step();

    // Random traffic.
    spur_en = 1;
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) k_exec = !k_exec;
      k_pvalid = $urandom_range(7) != 0;
      k_dready = $urandom_range(2) != 0;
      k_jmp  = $urandom_range(15) == 0;
      k_trap = $urandom_range(23) == 0;
      k_jpc  = $urandom & 32'hFFFF_FFFC;
      k_tpc  = $urandom & 32'hFFFF_FFFC;
      k_rst  = $urandom_range(199) == 0;
      step();
    end
    k_rst = 0; k_jmp = 0; k_trap = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
